// File: rtl/order_manager.sv
// Order queue for the kitchen game: spawns timed dish orders, matches deliveries,
// expires stale orders and keeps a saturating 0..15 score.
module order_manager #(
    parameter int ORDER_PERIOD = 600,
    parameter int ORDER_LIFE   = 1800
) (
    input  logic        vsync,
    input  logic        Reset_n,
    input  logic        StartFlag,
    input  logic        EndFlag,
    input  logic        deliver,
    input  logic [1:0]  deliver_dish,
    output logic [3:0]  score,
    output logic [2:0]  order_count,
    output logic [7:0]  order_dish,
    output logic [11:0] order_life0,
    output logic        deliver_hit,
    output logic        deliver_miss
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [11:0] LIFE_INIT     = 12'(ORDER_LIFE);
    localparam logic [11:0] PERIOD_RELOAD = 12'(ORDER_PERIOD - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_score, w_score_nxt;
    logic [2:0]  r_count, w_count_nxt;
    logic [1:0]  r_dish [4];
    logic [1:0]  w_dish_nxt [4];
    logic [11:0] r_life [4];
    logic [11:0] w_life_nxt [4];
    logic [11:0] r_spawn_cnt, w_spawn_cnt_nxt;
    logic [7:0]  r_lfsr, w_lfsr_nxt;
    logic        r_hit, w_hit_nxt;
    logic        r_miss, w_miss_nxt;

    logic [3:0]  w_match_vec;
    logic        w_match;
    logic [1:0]  w_match_idx;
    logic        w_expire;
    logic        w_inc, w_dec;
    logic [3:0]  w_keep;
    logic [2:0]  w_j;

    always_comb begin
        w_match_vec = '0;
        for (int unsigned i = 0; i < 4; i++)
            w_match_vec[i] = deliver && (3'(i) < r_count) && (r_dish[i] == deliver_dish);
        w_match = |w_match_vec;
        if (w_match_vec[0])      w_match_idx = 2'd0;
        else if (w_match_vec[1]) w_match_idx = 2'd1;
        else if (w_match_vec[2]) w_match_idx = 2'd2;
        else                     w_match_idx = 2'd3;
        w_expire = (r_count != 3'd0) && (r_life[0] == 12'd1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (StartFlag && !EndFlag) w_state_nxt = S_RUN;
            S_RUN:   if (EndFlag) w_state_nxt = S_DONE;
            default: w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        w_dish_nxt      = r_dish;
        w_life_nxt      = r_life;
        w_count_nxt     = r_count;
        w_score_nxt     = r_score;
        w_spawn_cnt_nxt = r_spawn_cnt;
        w_hit_nxt       = 1'b0;
        w_miss_nxt      = 1'b0;
        w_inc           = 1'b0;
        w_dec           = 1'b0;
        w_keep          = '0;
        w_j             = '0;
        w_lfsr_nxt      = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

        if (r_state == S_IDLE && w_state_nxt == S_RUN) begin
            w_dish_nxt[0]   = r_lfsr[1:0];
            w_life_nxt[0]   = LIFE_INIT;
            w_count_nxt     = 3'd1;
            w_spawn_cnt_nxt = PERIOD_RELOAD;
        end else if (r_state == S_RUN && w_state_nxt == S_DONE) begin
            w_dish_nxt  = '{default: '0};
            w_life_nxt  = '{default: '0};
            w_count_nxt = '0;
        end else if (r_state == S_RUN) begin
            w_hit_nxt  = w_match;
            w_miss_nxt = deliver && !w_match;
            // A delivery on the expiring slot 0 consumes it, so no expiry penalty.
            w_inc = w_match;
            w_dec = w_expire && !(w_match && w_match_idx == 2'd0);
            if (w_dec && !w_inc && r_score == 4'd0)
                w_score_nxt = r_score;
            else if (w_inc && !w_dec && r_score == 4'd15)
                w_score_nxt = r_score;
            else
                w_score_nxt = r_score + {3'd0, w_inc} - {3'd0, w_dec};

            for (int unsigned i = 0; i < 4; i++)
                w_keep[i] = (3'(i) < r_count) && !(w_match && w_match_idx == 2'(i))
                            && !(w_expire && i == 0);

            // Compact survivors toward slot 0, ageing them as they move.
            w_dish_nxt = '{default: '0};
            w_life_nxt = '{default: '0};
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_keep[i]) begin
                    w_dish_nxt[w_j[1:0]] = r_dish[i];
                    w_life_nxt[w_j[1:0]] = r_life[i] - 12'd1;
                    w_j = w_j + 3'd1;
                end
            end

            if (r_spawn_cnt == 12'd0) begin
                w_spawn_cnt_nxt = PERIOD_RELOAD;
                if (w_j != 3'd4) begin
                    w_dish_nxt[w_j[1:0]] = r_lfsr[1:0];
                    w_life_nxt[w_j[1:0]] = LIFE_INIT;
                    w_j = w_j + 3'd1;
                end
            end else begin
                w_spawn_cnt_nxt = r_spawn_cnt - 12'd1;
            end
            w_count_nxt = w_j;
        end
    end

    always_ff @(posedge vsync or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_score     <= '0;
            r_count     <= '0;
            r_dish      <= '{default: '0};
            r_life      <= '{default: '0};
            r_spawn_cnt <= '0;
            r_lfsr      <= 8'hA5;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_count     <= w_count_nxt;
            r_dish      <= w_dish_nxt;
            r_life      <= w_life_nxt;
            r_spawn_cnt <= w_spawn_cnt_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_hit       <= w_hit_nxt;
            r_miss      <= w_miss_nxt;
        end
    end

    assign score        = r_score;
    assign order_count  = r_count;
    assign order_dish   = {r_dish[3], r_dish[2], r_dish[1], r_dish[0]};
    assign order_life0  = r_life[0];
    assign deliver_hit  = r_hit;
    assign deliver_miss = r_miss;

endmodule
